// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter sequencing states
//   REQ_*       : fixed requester slot assignment (debug, data, fetch)
//   idx_w()     : width of an index able to address n requesters
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int REQ_DEBUG = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_FETCH = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester handshake and the memory command bus.
//   req_valid/req_we/req_addr/req_wdata : per-requester request payload
//   req_ready                           : one-hot grant back to requesters
//   resp_valid/resp_rdata               : one-cycle response to the owner
//   mem_en/mem_we/mem_addr/mem_wdata    : command to the memory array
//   mem_rdata                           : read data from the memory array
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and memory's view
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_we;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0]             resp_valid;
    logic [DATA_W-1:0]            resp_rdata;
    logic                         mem_en;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic [DATA_W-1:0]            mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: picks the first asserted req_valid bit
// at or above rr_ptr, wrapping past the top index.
//   req_valid : request vector
//   rr_ptr    : highest-priority index this cycle
//   grant     : one-hot winner (all zero when nothing is valid)
//   grant_idx : encoded winner (0 when nothing is valid)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down to offset 0 so the candidate
    // closest to rr_ptr is the last one written and therefore wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(rr_ptr) + off) % N_REQ);
            if (req_valid[cand]) begin
                grant     = N_REQ'(1) << cand;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single-ported memory between N_REQ requesters. One transaction is
// in flight at a time: grant (IDLE), command strobe (ISSUE), fixed latency
// wait (WAIT), one-cycle response to the owner (RESP).
//   clk   : system clock
//   reset : asynchronous, active-low; discards any in-flight transaction
//   bus   : mem_arbiter_if.slave (requester handshake + memory command bus)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_w(N_REQ);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner;
    logic              we_q;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        lat_cnt;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [N_REQ-1:0]  resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is only offered in IDLE; gating with reset keeps req_ready low
    // while reset is held, since the state register alone reads IDLE then.
    assign bus.req_ready  = (state == IDLE && reset) ? grant : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= IDX_W'(REQ_DEBUG);
            we_q         <= 1'b0;
            rdata_q      <= '0;
            lat_cnt      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A non-empty grant is the handshake: the picker only
                    // selects bits whose req_valid is set.
                    if (|grant) begin
                        owner       <= grant_idx;
                        rr_ptr      <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0
                                                                        : grant_idx + 1'b1;
                        we_q        <= bus.req_we[grant_idx];
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.req_we[grant_idx];
                        mem_addr_q  <= bus.req_addr[grant_idx];
                        mem_wdata_q <= bus.req_wdata[grant_idx];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Command strobe lasts exactly this one cycle.
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    lat_cnt     <= 3'(MEM_LATENCY - 1);
                    state       <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        // Writes keep the previous read data as their ack payload.
                        if (!we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        resp_rdata_q <= we_q ? rdata_q : bus.mem_rdata;
                        resp_valid_q <= N_REQ'(1) << owner;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= '0;
                    resp_rdata_q <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences all accesses to the core's single-ported unified memory and shares it between up to N_REQ requesters: debug/loader port, data load/store path, and instruction fetch. It sits between the multicycle control path (fetch/MEMREAD/MEMWRITE requests) and the memory array. It accepts one request at a time by round-robin, issues exactly one memory command, and waits a fixed memory latency. It then returns a one-cycle response to the winning requester.

## Interface
- N_REQ, 3, number of requesters (index 0 = debug, 1 = data, 2 = fetch)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (legal range 1..7)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  request pending, per requester
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ×ADDR_W  request address
- req_wdata  in  N_REQ×DATA_W  write data
- req_ready  out  N_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- resp_valid  out  N_REQ  one-hot, one-cycle pulse: read data or write ack
- resp_rdata  out  DATA_W  read data, valid only while any resp_valid bit is set
- mem_en  out  1  one-cycle memory command strobe
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: combinationally grant the first requester with req_valid set, searching upward from rr_ptr with wrap. Exactly that req_ready bit is high. No valid requests means req_ready = 0.
- On handshake: latch owner index, we, addr, and wdata. Set rr_ptr = (owner+1) mod N_REQ. Go to ISSUE.
- ISSUE: mem_en = 1. mem_we, mem_addr, and mem_wdata come from the latched values. Load lat_cnt = MEM_LATENCY−1. Go to WAIT.
- WAIT: while lat_cnt ≠ 0, decrement it. When lat_cnt == 0, capture mem_rdata into rdata_q (reads only; writes leave rdata_q unchanged). Go to RESP.
- RESP: resp_valid[owner] = 1 and resp_rdata = rdata_q. Go to IDLE.
- req_ready is 0 in every state except IDLE. A request is only accepted in IDLE. A request asserted during RESP is granted no earlier than the next cycle.
- Requesters must hold valid and payload until ready. A valid that drops before grant is simply not served, with no side effects.
- Only one transaction is outstanding. No pipelining.
- Reset (any state, mid-transaction included): state = IDLE, rr_ptr = 0, owner = 0, rdata_q = 0, lat_cnt = 0. All outputs are 0. An in-flight transaction is discarded and gets no response.

## Timing
- Handshake in cycle k, mem_en in k+1, mem_rdata sampled at end of cycle k+1+MEM_LATENCY, resp_valid in k+2+MEM_LATENCY.
- MEM_LATENCY = 1 gives a response 3 cycles after handshake and a next grant possible in cycle k+4.
- Worst-case wait for a continuously requesting port is (N_REQ−1) transactions.
- Outputs during reset are all zero. resp_rdata is 0 whenever resp_valid = 0.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - requester index constants REQ_DEBUG = 0, REQ_DATA = 1, REQ_FETCH = 2
- Sub-module rr_picker: combinational, takes req_valid and rr_ptr, returns a one-hot grant and the encoded index.
- The rest (FSM, latches, counter) lives in mem_arbiter.

## Test plan
- Single read: data port requests addr 42 and memory model returns 0xdeadbeef at latency 1 → req_ready[1] in k, mem_en/addr 42 in k+1, resp_valid[1] with 0xdeadbeef in k+3, no other resp bits.
- Write then read: debug writes 0xcafebabe to 46, then fetch reads 46 → mem_we = 1 only in the first ISSUE. Both responses are seen, and the fetch response carries 0xcafebabe.
- Contention: all three ports valid continuously after reset → grant order 0, 1, 2, 0, 1, 2. No port is granted twice before the others.
- Latency sweep: MEM_LATENCY = 3, read addr 34 returning 0xbadab00f → resp_valid in k+5. rdata_q is not sampled early (model drives garbage before valid).
- Reset mid-WAIT: assert reset during WAIT → all outputs 0 immediately, no resp_valid after release, rr_ptr = 0 so port 0 wins the next contention.
- Request during RESP: fetch raises valid in the RESP cycle → req_ready[2] is first high in the following IDLE cycle.
